// File: rtl/freq_div_prog.sv
// freq_div_prog: runtime-programmable clock divider with shadowed ratio/duty and clean start/stop
module freq_div_prog #(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] div_ratio,
  input  logic             div_load,
  input  logic             duty_mode,
  output logic             out_clk,
  output logic             tick,
  output logic             pending,
  output logic             running
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(RESET_DIV);
  state_t state_q, state_d;
  logic [WIDTH-1:0] ph_q, ph_d, n_q, n_d, sh_n_q, sh_n_d, ld_n, nx_n, high, ph_nx;
  logic duty_q, duty_d, sh_duty_q, sh_duty_d, nx_duty;
  logic out_q, out_d, tick_q, pend_q, pend_d, byp_q, byp_d, act, bnd, apply, to_idle;
  // Next-state: a period restarts (and takes the shadow) on IDLE->RUN or on a boundary that keeps running
  always_comb begin
    ld_n      = (div_ratio == '0) ? ONE : div_ratio;
    nx_n      = div_load ? ld_n : sh_n_q;
    nx_duty   = div_load ? duty_mode : sh_duty_q;
    act       = state_q != IDLE;
    bnd       = act && (ph_q == n_q - ONE);
    state_d   = !act ? (en ? RUN : IDLE) : (en ? RUN : (bnd ? IDLE : DRAIN));
    apply     = en && (!act || bnd);
    to_idle   = state_d == IDLE;
    high      = duty_q ? ONE : (n_q >> 1) + {{(WIDTH-1){1'b0}}, n_q[0]};
    ph_nx     = ph_q + ONE;
    ph_d      = (apply || to_idle) ? '0 : ph_nx;
    out_d     = apply ? 1'b1 : (to_idle ? 1'b0 : (ph_nx < high));
    n_d       = apply ? nx_n : n_q;
    duty_d    = apply ? nx_duty : duty_q;
    byp_d     = apply ? (nx_n == ONE) : (to_idle ? 1'b0 : byp_q);
    sh_n_d    = div_load ? ld_n : sh_n_q;
    sh_duty_d = div_load ? duty_mode : sh_duty_q;
    pend_d    = !apply && (div_load || pend_q);
  end
  // State, phase, active/shadow registers; async reset drops the output immediately
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ph_q      <= '0;
      out_q     <= 1'b0;
      tick_q    <= 1'b0;
      pend_q    <= 1'b0;
      byp_q     <= 1'b0;
      n_q       <= RST_DIV;
      duty_q    <= 1'b0;
      sh_n_q    <= RST_DIV;
      sh_duty_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      out_q     <= out_d;
      tick_q    <= apply;
      pend_q    <= pend_d;
      byp_q     <= byp_d;
      n_q       <= n_d;
      duty_q    <= duty_d;
      sh_n_q    <= sh_n_d;
      sh_duty_q <= sh_duty_d;
    end
  end
  assign out_clk = byp_q ? clk : out_q;
  assign tick    = tick_q;
  assign pending = pend_q;
  assign running = state_q != IDLE;
endmodule

// File: tb/tb_freq_div_prog.sv
// tb_freq_div_prog: table-driven and directed checks of the programmable divider
module tb_freq_div_prog;
  logic clk = 1'b0, reset = 1'b0, en = 1'b0, div_load = 1'b0, duty_mode = 1'b0;
  logic [7:0] div_ratio = '0;
  logic out_clk, tick, pending, running;
  int total = 0, bad = 0;
  typedef struct {
    logic en, ld;
    logic [7:0] r;
    logic dm, o, t, p, rn;
  } vec_t;
  vec_t tv[$];
  freq_div_prog #(.WIDTH(8), .RESET_DIV(2)) dut (
    .clk(clk), .reset(reset), .en(en), .div_ratio(div_ratio), .div_load(div_load),
    .duty_mode(duty_mode), .out_clk(out_clk), .tick(tick), .pending(pending), .running(running)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic drv(input logic e, input logic l, input logic [7:0] r, input logic d);
    en = e; div_load = l; div_ratio = r; duty_mode = d;
  endtask
  task automatic chk4(input string name, input logic o, input logic t, input logic p, input logic rn);
    chk({name, ".out_clk"}, out_clk, o);
    chk({name, ".tick"}, tick, t);
    chk({name, ".pending"}, pending, p);
    chk({name, ".running"}, running, rn);
  endtask
  initial begin
    // en ld ratio duty | out tick pend run
    tv.push_back('{1,0,0,0, 1,1,0,1});
    tv.push_back('{1,0,0,0, 0,0,0,1});
    tv.push_back('{1,0,0,0, 1,1,0,1});
    tv.push_back('{1,1,5,0, 0,0,1,1});
    tv.push_back('{1,0,0,0, 1,1,0,1});
    tv.push_back('{1,0,0,0, 1,0,0,1});
    tv.push_back('{1,0,0,0, 1,0,0,1});
    tv.push_back('{1,0,0,0, 0,0,0,1});
    tv.push_back('{1,0,0,0, 0,0,0,1});
    tv.push_back('{1,0,0,0, 1,1,0,1});
    tv.push_back('{1,1,4,1, 1,0,1,1});
    tv.push_back('{1,0,0,0, 1,0,1,1});
    tv.push_back('{1,0,0,0, 0,0,1,1});
    tv.push_back('{1,0,0,0, 0,0,1,1});
    tv.push_back('{1,0,0,0, 1,1,0,1});
    tv.push_back('{1,0,0,0, 0,0,0,1});
    tv.push_back('{1,0,0,0, 0,0,0,1});
    tv.push_back('{1,0,0,0, 0,0,0,1});
    tv.push_back('{1,0,0,0, 1,1,0,1});
    tv.push_back('{1,0,0,0, 0,0,0,1});
    tv.push_back('{1,0,0,0, 0,0,0,1});
    tv.push_back('{1,0,0,0, 0,0,0,1});
    tv.push_back('{1,1,3,0, 1,1,0,1});
    tv.push_back('{1,0,0,0, 1,0,0,1});
    tv.push_back('{1,0,0,0, 0,0,0,1});
    tv.push_back('{1,0,0,0, 1,1,0,1});
    tv.push_back('{1,1,7,0, 1,0,1,1});
    tv.push_back('{1,1,2,0, 0,0,1,1});
    tv.push_back('{1,0,0,0, 1,1,0,1});
    tv.push_back('{1,0,0,0, 0,0,0,1});
    tv.push_back('{1,0,0,0, 1,1,0,1});
    tv.push_back('{1,1,6,0, 0,0,1,1});
    tv.push_back('{1,0,0,0, 1,1,0,1});
    tv.push_back('{1,0,0,0, 1,0,0,1});
    tv.push_back('{0,0,0,0, 1,0,0,1});
    tv.push_back('{0,0,0,0, 0,0,0,1});
    tv.push_back('{0,0,0,0, 0,0,0,1});
    tv.push_back('{0,0,0,0, 0,0,0,1});
    tv.push_back('{0,0,0,0, 0,0,0,0});
    tv.push_back('{0,0,0,0, 0,0,0,0});
    #13;
    chk4("reset_hold", 0, 0, 0, 0);
    reset = 1'b1;
    cyc();
    chk4("after_release", 0, 0, 0, 0);
    for (int i = 0; i < tv.size(); i++) begin
      drv(tv[i].en, tv[i].ld, tv[i].r, tv[i].dm);
      cyc();
      chk4($sformatf("vec%0d", i), tv[i].o, tv[i].t, tv[i].p, tv[i].rn);
    end
    drv(1, 1, 8'd1, 0);
    cyc();
    chk4("byp1_hi", 1, 1, 0, 1);
    drv(1, 0, 0, 0);
    @(negedge clk);
    #2;
    chk("byp1_lo.out_clk", out_clk, 1'b0);
    chk("byp1_lo.tick", tick, 1'b1);
    drv(1, 1, 8'd0, 0);
    cyc();
    chk4("byp0_hi", 1, 1, 0, 1);
    drv(1, 0, 0, 0);
    @(negedge clk);
    #2;
    chk("byp0_lo.out_clk", out_clk, 1'b0);
    drv(1, 1, 8'd3, 0);
    cyc();
    chk4("n3_ph0", 1, 1, 0, 1);
    drv(1, 0, 0, 0);
    @(negedge clk);
    #2;
    chk("n3_ph0_lo.out_clk", out_clk, 1'b1);
    cyc();
    chk4("n3_ph1", 1, 0, 0, 1);
    cyc();
    chk4("n3_ph2", 0, 0, 0, 1);
    cyc();
    chk4("n3_wrap", 1, 1, 0, 1);
    drv(1, 1, 8'd7, 0);
    cyc();
    drv(1, 0, 0, 0);
    cyc();
    cyc();
    chk4("n7_ph0", 1, 1, 0, 1);
    cyc();
    drv(1, 1, 8'd5, 0);
    cyc();
    drv(1, 0, 0, 0);
    chk4("n7_ph2", 1, 0, 1, 1);
    #1 reset = 1'b0;
    #1;
    chk4("async_reset", 0, 0, 0, 0);
    #10 reset = 1'b1;
    cyc();
    chk4("post_rst_ph0", 1, 1, 0, 1);
    cyc();
    chk4("post_rst_ph1", 0, 0, 0, 1);
    cyc();
    chk4("post_rst_wrap", 1, 1, 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
